// File: rtl/dpram_burst_reader.sv
// Read-side burst master for a registered-output dual-port RAM: walks a
// (start address, length) command and streams the words out valid/ready.
module dpram_burst_reader #(
  parameter int AWIDTH    = 11,
  parameter int NUM_WORDS = 2048,
  parameter int DWIDTH    = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] start_addr,
  input  logic [AWIDTH:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_address,
  output logic              ram_wren,
  input  logic [DWIDTH-1:0] ram_out,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [AWIDTH:0]   LP_MAX_LEN   = (AWIDTH+1)'(NUM_WORDS);
  localparam logic [AWIDTH-1:0] LP_LAST_ADDR = AWIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [AWIDTH-1:0]   r_ptr;
  logic [AWIDTH:0]     r_issue_cnt;
  logic [AWIDTH:0]     r_pop_cnt;
  logic                r_inflight;
  logic                r_done;
  logic [DWIDTH-1:0]   r_fifo [2];
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_count;

  logic [AWIDTH:0]     w_len;
  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  logic                w_accept;
  logic                w_zero_cmd;
  logic                w_final;
  logic [2:0]          w_occ;

  assign w_len  = (num_words > LP_MAX_LEN) ? LP_MAX_LEN : num_words;
  assign w_pop  = out_valid & out_ready;
  assign w_push = r_inflight;
  // Occupancy the FIFO will have once everything already requested lands.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_issue    = 1'b0;
    w_accept   = 1'b0;
    w_zero_cmd = 1'b0;
    w_final    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_len != '0) begin
            w_accept = 1'b1;
            w_next   = READ;
          end else begin
            w_zero_cmd = 1'b1;
          end
        end
      end
      READ: begin
        if (w_occ < 3'd2) begin
          w_issue = 1'b1;
          if (r_issue_cnt == (AWIDTH+1)'(1)) w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && r_pop_cnt == (AWIDTH+1)'(1)) begin
          w_final = 1'b1;
          w_next  = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_done     <= w_zero_cmd | w_final;
      r_inflight <= w_issue;
      if (w_accept) begin
        r_ptr       <= start_addr;
        r_issue_cnt <= w_len;
      end else if (w_issue) begin
        r_ptr       <= (r_ptr == LP_LAST_ADDR) ? '0 : r_ptr + 1'b1;
        r_issue_cnt <= r_issue_cnt - 1'b1;
      end
      if (w_accept)   r_pop_cnt <= w_len;
      else if (w_pop) r_pop_cnt <= r_pop_cnt - 1'b1;
      // RAM data returns one cycle after issue and goes straight into the FIFO.
      if (w_push) begin
        r_fifo[r_wptr] <= ram_out;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign ram_address = r_ptr;
  assign ram_wren    = 1'b0;
  assign out_valid   = (r_count != 2'd0);
  assign out_data    = r_fifo[r_rptr];
  assign out_last    = out_valid && (r_pop_cnt == (AWIDTH+1)'(1));

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Directed bench for dpram_burst_reader: behavioural RAM holding mem[i]=i,
// a table of bursts checked against an address model, plus corner sequences.
module tb_dpram_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] start_addr;
  logic [11:0] num_words;
  logic        busy, done, ram_wren, out_valid, out_ready, out_last;
  logic [10:0] ram_address;
  logic [39:0] ram_out, out_data;
  logic [39:0] mem [2048];

  int checks   = 0;
  int failures = 0;

  dpram_burst_reader #(.AWIDTH(11), .NUM_WORDS(2048), .DWIDTH(40)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .num_words(num_words), .busy(busy), .done(done), .ram_address(ram_address),
    .ram_wren(ram_wren), .ram_out(ram_out), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_out <= mem[ram_address];

  typedef struct {
    logic [10:0] addr;
    logic [11:0] n;
    int          mode;
    int          exp_n;
    bit          poke;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    logic [5:0] pat;
    pat = 6'b101001;  // bit i = ready in cycle i: 1,0,0,1,0,1
    case (mode)
      0:       return 1'b1;
      1:       return pat[cyc % 6];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_burst(input logic [10:0] addr, input logic [11:0] n,
                           input int mode, input int exp_n, input bit poke);
    int k = 0, cyc = 0, bad_data = 0, bad_last = 0, bad_stab = 0;
    logic stalled = 1'b0;
    bit poked = 1'b0;
    logic [39:0] held = '0;
    logic [39:0] exp_d;
    @(negedge clk);
    start = 1'b1; start_addr = addr; num_words = n;
    @(negedge clk);
    start = 1'b0;
    chk("burst busy after start", busy, 1'b1);
    while (!done && cyc < 10000) begin
      out_ready = ready_pat(mode, cyc);
      if (poke && !poked && k == 10) begin
        start = 1'b1; start_addr = 11'd999; num_words = 12'd5; poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (stalled && (!out_valid || out_data !== held)) bad_stab++;
      if (out_valid) begin
        if (out_last !== (k == exp_n - 1)) bad_last++;
        if (out_ready) begin
          exp_d = 40'((int'(addr) + k) % 2048);
          if (out_data !== exp_d) bad_data++;
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end else begin
        stalled = 1'b0;
        if (out_last) bad_last++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("burst done pulse", done, 1'b1);
    chk("burst busy at done", busy, 1'b0);
    chk("burst valid at done", out_valid, 1'b0);
    chk("burst transfer count", 64'(k), 64'(exp_n));
    chk("burst data errors", 64'(bad_data), 0);
    chk("burst last errors", 64'(bad_last), 0);
    chk("burst stall stability errors", 64'(bad_stab), 0);
    @(negedge clk);
    chk("burst done single cycle", done, 1'b0);
    chk("burst stays idle", busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 40'(i);
    vecs[0] = '{11'd5,    12'd4,    0, 4,    1'b0};
    vecs[1] = '{11'd2046, 12'd4,    0, 4,    1'b0};
    vecs[2] = '{11'd100,  12'd8,    1, 8,    1'b0};
    vecs[3] = '{11'd2040, 12'd16,   2, 16,   1'b0};
    vecs[4] = '{11'd0,    12'd1,    0, 1,    1'b0};
    vecs[5] = '{11'd7,    12'd4095, 0, 2048, 1'b1};
    vecs[6] = '{11'd3,    12'd2048, 1, 2048, 1'b0};

    reset = 1'b1; start = 1'b0; start_addr = '0; num_words = '0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset valid", out_valid, 1'b0);
    chk("reset last", out_last, 1'b0);
    chk("reset data", out_data, 0);
    chk("reset address", ram_address, 0);
    chk("wren low", ram_wren, 1'b0);
    reset = 1'b0;

    // Cycle-exact latency: start_addr=5, num_words=4, ready high.
    @(negedge clk);
    start = 1'b1; start_addr = 11'd5; num_words = 12'd4;
    @(negedge clk);
    start = 1'b0;
    chk("lat c1 busy", busy, 1'b1);
    chk("lat c1 address", ram_address, 11'd5);
    chk("lat c1 valid", out_valid, 1'b0);
    @(negedge clk);
    chk("lat c2 address", ram_address, 11'd6);
    chk("lat c2 valid", out_valid, 1'b0);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      chk("lat valid", out_valid, 1'b1);
      chk("lat data", out_data, 40'(c + 2));
      chk("lat last", out_last, c == 6);
      chk("lat no early done", done, 1'b0);
    end
    @(negedge clk);
    chk("lat c7 done", done, 1'b1);
    chk("lat c7 busy", busy, 1'b0);
    chk("lat c7 valid", out_valid, 1'b0);

    // Zero-length command: done next cycle, no RAM activity.
    @(negedge clk);
    start = 1'b1; start_addr = 11'd300; num_words = 12'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero done", done, 1'b1);
    chk("zero busy", busy, 1'b0);
    chk("zero valid", out_valid, 1'b0);
    chk("zero address held", ram_address, 11'd9);
    @(negedge clk);
    chk("zero done pulse ends", done, 1'b0);
    chk("zero still idle", busy, 1'b0);

    for (int v = 0; v < 7; v++)
      run_burst(vecs[v].addr, vecs[v].n, vecs[v].mode, vecs[v].exp_n, vecs[v].poke);

    // Async reset while a read is in flight.
    @(negedge clk);
    out_ready = 1'b0; start = 1'b1; start_addr = 11'd20; num_words = 12'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort valid", out_valid, 1'b0);
    chk("abort last", out_last, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort address", ram_address, 0);
    chk("abort data", out_data, 0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("abort no done", done, 1'b0);
    chk("abort no valid", out_valid, 1'b0);
    run_burst(11'd0, 12'd2, 0, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_burst_reader.md
Name: dpram_burst_reader

Overview:
- Read-side master for the 2048x40 dual-port RAM: takes a (start address, length) command and drives one RAM port with sequential read addresses.
- Absorbs the RAM's 1-cycle registered read latency and presents the words as a valid/ready stream with full throughput under backpressure.
- Sits between a weight/activation buffer and the downstream compute pipeline; the RAM's other port stays free for the writer.

Parameters:
- AWIDTH, 11, RAM address width
- NUM_WORDS, 2048, RAM depth; addresses wrap modulo NUM_WORDS
- DWIDTH, 40, data word width

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  command strobe, sampled only in IDLE
- start_addr  input  AWIDTH  first RAM address of the burst
- num_words  input  AWIDTH+1  burst length 0..NUM_WORDS; values above NUM_WORDS saturate to NUM_WORDS
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at burst completion
- ram_address  output  AWIDTH  to the RAM port address
- ram_wren  output  1  to the RAM port write enable; constant 0
- ram_out  input  DWIDTH  RAM port read data, valid 1 cycle after ram_address is presented
- out_data  output  DWIDTH  stream data, head of internal FIFO
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready; a transfer occurs when out_valid and out_ready are both high
- out_last  output  1  high with the final word of the burst

Behaviour:
- Reset (async assert, clocked release):
  - State IDLE; busy, done, out_valid and out_last are 0; out_data is 0; ram_address is 0; FIFO is emptied.
  - Any in-flight read is discarded.
  - Reset mid-burst aborts the burst with no done pulse.
- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ on start=1 with num_words>0. Latch the address pointer = start_addr, issue_cnt = pop_cnt = num_words.
  - IDLE, start=1, num_words=0: done pulses the next cycle, no RAM access, stays IDLE.
  - READ -> DRAIN when the last read is issued (issue_cnt reaches 0).
  - DRAIN -> IDLE on the transfer of the final word. done=1 and busy=0 in the following cycle.
  - start is ignored while busy. A start in the done cycle is accepted.
- Read issue:
  - ram_address is the registered pointer.
  - A read is issued in a READ cycle iff fifo_count + inflight - pop < 2, where pop = out_valid & out_ready.
  - On issue: the pointer increments, wrapping from NUM_WORDS-1 to 0; issue_cnt decrements; inflight is set for the next cycle.
  - In a cycle with inflight=1, ram_out is written into the FIFO at that cycle's closing edge.
- FIFO:
  - 2 entries, simultaneous push and pop allowed. It never overflows because of the issue rule.
  - out_valid = (fifo_count > 0); out_data is the head entry.
  - out_last = out_valid and pop_cnt==1; pop_cnt decrements on each transfer.
- Latency:
  - start sampled at edge 0 -> ram_address=start_addr in cycle 1 -> first out_valid in cycle 3.
  - With out_ready held high: one word per cycle, and an N-word burst transfers its last word in cycle N+2.
- Backpressure:
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
  - Reads stall; no word is lost or duplicated.

Test Plan:
- RAM preloaded with mem[i]=i; start_addr=5, num_words=4, out_ready=1 -> out_data 5,6,7,8 in cycles 3-6, out_last only with 8, done pulse in cycle 7.
- start_addr=2046, num_words=4 -> ram_address sequence 2046,2047,0,1; data in that order.
- num_words=8, out_ready toggling 1,0,0,1,0,1... -> exactly 8 transfers, in order, data stable while stalled, FIFO count never exceeds 2.
- num_words=0 -> done pulse in cycle 1; out_valid and busy never high; ram_address unchanged.
- num_words=4095 -> exactly 2048 words transferred; second start during busy is ignored.
- Reset asserted asynchronously mid-burst with 1 word in flight -> outputs 0 immediately; a new burst with start_addr=0, num_words=2 afterwards returns mem[0], mem[1] only.
